// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Receives a byte stream and writes it into an instruction memory as
//   16-bit words. The stream is a 16-bit word count N (high byte first)
//   followed by N words, each sent as high byte then low byte.
//
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
//   checksum byte (XOR of all 2N data bytes). A mismatch sets err.
//
// Parameters
//   DEPTH  number of 16-bit words in the target memory (longer loads -> err)
//   BASE   first write address (word address, same space as pc)
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle load request, honoured only while idle
//   byte_in       incoming byte
//   byte_valid    byte_in holds a valid byte
//   byte_ready    loader accepts byte_in this cycle
//   we            memory write strobe, one cycle per word
//   waddr, wdata  memory write address / data
//   busy          high whenever the loader is not idle
//   done          one-cycle pulse when a load finishes (good or bad)
//   err           sticky error flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int          DEPTH = 256,
  parameter logic [15:0] BASE  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    CSUM    = 3'd6,
    FIN     = 3'd7
  } state_t;
  // State entered once all words (or none) have been written.
  localparam state_t LAST_ST = CSUM;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    FIN     = 3'd7
  } state_t;
  localparam state_t LAST_ST = FIN;
`endif

  // Widened so a count of 16'hFFFF compares correctly against DEPTH.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_r;
  state_t      state_nx_s;
  logic        byte_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        we_r;
  logic        err_r;
  logic [15:0] waddr_r;
  logic [15:0] wdata_r;
  logic [15:0] len_r;
  logic [15:0] cnt_r;
  logic [7:0]  hi_r;
  logic        xfer_s;
  logic [15:0] len_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;

  // Running checksum: plain XOR of every data byte.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // States in which a byte may be accepted.
  function automatic logic is_rx(input state_t s);
    logic r;
    case (s)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:                             r = 1'b1;
`endif
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

  assign xfer_s = byte_valid && byte_ready_r;
  // Full count as it becomes known during the LEN_LO transfer.
  assign len_s  = {len_r[15:8], byte_in};

  // Next-state decode; every receive state stalls until a transfer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nx_s = LEN_HI;
        else       state_nx_s = IDLE;
      end
      LEN_HI: begin
        if (xfer_s) state_nx_s = LEN_LO;
        else        state_nx_s = LEN_HI;
      end
      LEN_LO: begin
        if (!xfer_s)                         state_nx_s = LEN_LO;
        else if (len_s == 16'd0)             state_nx_s = LAST_ST;
        else if ({1'b0, len_s} > DEPTH_W)    state_nx_s = FIN;
        else                                 state_nx_s = DATA_HI;
      end
      DATA_HI: begin
        if (xfer_s) state_nx_s = DATA_LO;
        else        state_nx_s = DATA_HI;
      end
      DATA_LO: begin
        if (xfer_s) state_nx_s = WRITE;
        else        state_nx_s = DATA_LO;
      end
      WRITE: begin
        if (cnt_r + 16'd1 == len_r) state_nx_s = LAST_ST;
        else                        state_nx_s = DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer_s) state_nx_s = FIN;
        else        state_nx_s = CSUM;
      end
`endif
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register; control outputs are registered from the next state
  // so they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      we_r         <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      byte_ready_r <= is_rx(state_nx_s);
      busy_r       <= (state_nx_s != IDLE);
      done_r       <= (state_nx_s == FIN);
      we_r         <= (state_nx_s == WRITE);
    end
  end

  // Datapath: length capture, word assembly, address/counter, error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_r <= BASE;
      wdata_r <= 16'h0000;
      len_r   <= 16'h0000;
      cnt_r   <= 16'h0000;
      hi_r    <= 8'h00;
      err_r   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r  <= 8'h00;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            err_r   <= 1'b0;
            waddr_r <= BASE;
            cnt_r   <= 16'h0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r  <= 8'h00;
`endif
          end
        end
        LEN_HI: begin
          if (xfer_s) len_r[15:8] <= byte_in;
        end
        LEN_LO: begin
          if (xfer_s) begin
            len_r[7:0] <= byte_in;
            // Oversized load: flag it and write nothing.
            if ({1'b0, len_s} > DEPTH_W) err_r <= 1'b1;
          end
        end
        DATA_HI: begin
          if (xfer_s) begin
            hi_r   <= byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r <= csum_fold(csum_r, byte_in);
`endif
          end
        end
        DATA_LO: begin
          if (xfer_s) begin
            // wdata is loaded on entry to WRITE and held through the strobe.
            wdata_r <= {hi_r, byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r  <= csum_fold(csum_r, byte_in);
`endif
          end
        end
        WRITE: begin
          // Address wraps naturally at 16 bits.
          waddr_r <= waddr_r + 16'd1;
          cnt_r   <= cnt_r + 16'd1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (xfer_s && (byte_in != csum_r)) err_r <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign we         = we_r;
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam logic [15:0] BASE_A = 16'h0000;
  localparam logic [15:0] BASE_B = 16'hFFFF;
  localparam int          DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready_a, byte_ready_b;
  logic        we_a, we_b;
  logic [15:0] waddr_a, waddr_b, wdata_a, wdata_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  int tests = 0;
  int fails = 0;

  logic [31:0] qwa[$];
  logic [31:0] qwb[$];
  logic        qda[$];
  logic        qdb[$];
  logic [15:0] wq[$];

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .BASE(BASE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready_a), .we(we_a),
    .waddr(waddr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  imem_loader #(.DEPTH(DEPTH), .BASE(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready_b), .we(we_b),
    .waddr(waddr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Write monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_a) begin
        if (qwa.size() == 0) flag("unexpected write dut_a");
        else check("write_a", {waddr_a, wdata_a}, qwa.pop_front());
      end
      if (we_b) begin
        if (qwb.size() == 0) flag("unexpected write dut_b");
        else check("write_b", {waddr_b, wdata_b}, qwb.pop_front());
      end
      if (done_a) begin
        if (qda.size() == 0) flag("unexpected done dut_a");
        else check("done_err_a", 32'(err_a), 32'(qda.pop_front()));
      end
      if (done_b) begin
        if (qdb.size() == 0) flag("unexpected done dut_b");
        else check("done_err_b", 32'(err_b), 32'(qdb.pop_front()));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!(byte_ready_a && byte_ready_b) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("byte_ready timeout");
    @(negedge clk);
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy_a || busy_b) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) flag("busy timeout");
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy_a), 32'd1);
    check("err_cleared_by_start", 32'(err_a), 32'd0);
  endtask

  // Full load of wq[0..n-1]; gap drops valid after each byte, poke pulses
  // start while busy, bad corrupts the checksum byte (when present).
  task automatic do_load(input int n, input bit gap, input bit bad, input bit poke);
    logic [15:0] nn;
    logic [7:0]  cs;
    bit          over;
    logic        exp_err;
    nn   = 16'(n);
    cs   = 8'h00;
    over = (n > DEPTH);
    exp_err = over;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!over && bad) exp_err = 1'b1;
`endif
    if (!over) begin
      for (int i = 0; i < n; i++) begin
        qwa.push_back({BASE_A + 16'(i), wq[i]});
        qwb.push_back({BASE_B + 16'(i), wq[i]});
      end
    end
    qda.push_back(exp_err);
    qdb.push_back(exp_err);
    pulse_start();
    send_byte(nn[15:8], gap);
    send_byte(nn[7:0], gap);
    if (!over) begin
      if (poke) begin
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
        send_byte(wq[i][15:8], gap);
        send_byte(wq[i][7:0], gap);
        cs = cs ^ wq[i][15:8] ^ wq[i][7:0];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad ? (cs ^ 8'h01) : cs, gap);
`endif
    end
    byte_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       32'(busy_a),       32'd0);
    check({tag, "_byte_ready"}, 32'(byte_ready_a), 32'd0);
    check({tag, "_we"},         32'(we_a),         32'd0);
    check({tag, "_done"},       32'(done_a),       32'd0);
    check({tag, "_err"},        32'(err_a),        32'd0);
    check({tag, "_waddr_a"},    32'(waddr_a),      32'h0000);
    check({tag, "_waddr_b"},    32'(waddr_b),      32'h0000_FFFF);
    check({tag, "_wdata"},      32'(wdata_a),      32'h0000);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two words, valid held high.
    wq = {16'h1234, 16'hABCD};
    do_load(2, 1'b0, 1'b0, 1'b0);
    check("err_after_good", 32'(err_a), 32'd0);

    // Same load with valid toggling.
    wq = {16'h1234, 16'hABCD};
    do_load(2, 1'b1, 1'b0, 1'b0);

    // Oversized count (257): no writes, sticky err.
    do_load(257, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky_a", 32'(err_a), 32'd1);
    check("err_sticky_b", 32'(err_b), 32'd1);

    // Empty load: start clears err, done with err=0.
    do_load(0, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    wq = {16'h1234};
    do_load(1, 1'b0, 1'b0, 1'b0);
    check("csum_good_err", 32'(err_a), 32'd0);
    wq = {16'h1234};
    do_load(1, 1'b0, 1'b1, 1'b0);
    check("csum_bad_err", 32'(err_a), 32'd1);
`endif

    // Reset after the first word of a 3-word load.
    qwa.push_back({16'h0000, 16'h1122});
    qwb.push_back({16'hFFFF, 16'h1122});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("midload_we", 32'(we_a), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wq = {16'h5566};
    do_load(1, 1'b0, 1'b0, 1'b0);

    // Address wrap on dut_b plus a start pulse while busy.
    wq = {16'hBEEF, 16'hCAFE};
    do_load(2, 1'b0, 1'b0, 1'b1);

    // Exactly DEPTH words.
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back({8'(i), ~8'(i)});
    do_load(DEPTH, 1'b0, 1'b0, 1'b0);
    check("full_depth_err", 32'(err_a), 32'd0);

    repeat (3) @(negedge clk);
    check("writes_left_a", 32'(qwa.size()), 32'd0);
    check("writes_left_b", 32'(qwb.size()), 32'd0);
    check("dones_left_a",  32'(qda.size()), 32'd0);
    check("dones_left_b",  32'(qdb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of 16-bit words in the target instruction memory.
REQ-002 Parameter BASE, default 16'h0000, first write address (matches pc of first instruction).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 byte_in  input  8  incoming byte stream.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-009 we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 waddr  output  16  write address (word address, same space as pc).
REQ-011 wdata  output  16  instruction word to write.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a load finishes (good or bad).
REQ-014 err  output  1  sticky error flag; cleared by the next accepted start.

Function
REQ-015 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, FIN.
REQ-016 Stream format: 16-bit word count N (high byte first), then N words, each high byte then low byte.
REQ-017 IDLE: start=1 -> LEN_HI next cycle, clear err, waddr<=BASE, word counter<=0; start outside IDLE ignored.
REQ-018 byte_ready SHALL be high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM; a state advances only on a transfer, stalls otherwise.
REQ-019 LEN_LO transfer: N=0 -> CSUM (macro on) or FIN; N>DEPTH -> err=1, FIN, no writes; else DATA_HI.
REQ-020 DATA_LO transfer -> WRITE; in WRITE we=1 for exactly one cycle with wdata={hi,lo} and waddr current.
REQ-021 Cycle after WRITE: waddr+1, counter+1; counter reaching N -> CSUM (macro on) or FIN, else DATA_HI.
REQ-022 Minimum latency: 3 cycles per word (DATA_HI, DATA_LO, WRITE) with byte_valid held high.
REQ-023 waddr SHALL wrap modulo 2^16 (BASE+N-1 may exceed 16'hFFFF only by wrapping; no error).
REQ-024 FIN: done=1 for one cycle, then IDLE; err holds its value until the next start.
REQ-025 we SHALL never assert outside WRITE; wdata/waddr SHALL be stable while we=1.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, byte_ready=0, we=0, busy=0, done=0, err=0, waddr=BASE, wdata=0, counter=0.
REQ-027 Reset mid-load SHALL abandon the load with no further writes and no done pulse; already-written words are not undone.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last word one checksum byte is received in CSUM; it must equal XOR of all 2N data bytes, mismatch sets err; CSUM -> FIN.
REQ-029 Macro undefined: CSUM state and checksum logic absent; last WRITE (or N=0) goes directly to FIN.

Verification
REQ-030 Reset, start, bytes 00 02 12 34 AB CD (macro off), valid held -> we at addr 0000 data 1234, addr 0001 data ABCD, done pulse, err=0.
REQ-031 Same load with byte_valid toggling every other cycle -> identical writes, no duplicate or skipped word, we pulses exactly twice.
REQ-032 Count bytes 01 01 (N=257, DEPTH=256) -> no we, err=1, done pulse, next start clears err.
REQ-033 Macro on, bytes 00 01 12 34 26 -> write 1234 @0000, err=0; repeat with checksum 27 -> same write, err=1.
REQ-034 rst_n low after first word written of a 3-word load -> outputs at reset values same cycle, no done, later start loads cleanly from BASE.
REQ-035 BASE=16'hFFFF, N=2 -> writes at FFFF then 0000; start pulsed while busy -> ignored.
